// File: rtl/mem_req_if.sv
// rtl/mem_req_if.sv - CPU request/response and data-memory port bundle for mem_req_ctrl
interface mem_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_ready, mem_err,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
    input  mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_ready, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
    output mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - load/store request controller for a stalling 16-bit data memory
// Optional MEM_REQ_CTRL_STATS_EN adds stat_accesses / stat_wait_cycles counters.
module mem_req_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_req_if.slave    bus
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [31:0] stat_accesses,
  output logic [31:0] stat_wait_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = (MAX_WAIT == 0) ? '0 : CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic             wr_q;
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      rdata_q;
  logic             err_q;
  logic             timeout_q;

  logic             accept;
  logic             busy;
  logic             timeout_hit;

  assign busy        = (state == BUSY);
  assign bus.req_ready = (state == IDLE) || (state == DONE);
  assign accept      = bus.req_valid && bus.req_ready;
  assign timeout_hit = (MAX_WAIT != 0) && (wait_cnt == LAST_WAIT);

  // Memory port is decoded from state so an async reset drops it at once.
  assign bus.mem_enable = busy;
  assign bus.mem_wr     = busy ? wr_q    : 1'b0;
  assign bus.mem_addr   = busy ? addr_q  : 16'h0000;
  assign bus.mem_wdata  = busy ? wdata_q : 16'h0000;

  assign bus.resp_valid   = (state == DONE);
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_err     = err_q;
  assign bus.resp_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wait_cnt  <= '0;
      rdata_q   <= 16'h0000;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            wr_q    <= bus.req_wr;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (bus.req_addr[0]) begin
              // Misaligned: answer locally without touching memory.
              state     <= DONE;
              rdata_q   <= 16'h0000;
              err_q     <= 1'b1;
              timeout_q <= 1'b0;
            end else begin
              state    <= BUSY;
              wait_cnt <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            state     <= DONE;
            rdata_q   <= wr_q ? 16'h0000 : bus.mem_rdata;
            err_q     <= bus.mem_err;
            timeout_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) begin
              state     <= DONE;
              rdata_q   <= 16'h0000;
              err_q     <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_REQ_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_accesses    <= 32'd0;
      stat_wait_cycles <= 32'd0;
    end else if (busy) begin
      if (bus.mem_ready || timeout_hit) stat_accesses <= stat_accesses + 32'd1;
      if (!bus.mem_ready) stat_wait_cycles <= stat_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl (MAX_WAIT=4)
module tb_mem_req_ctrl;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_acc   = 0;
  int   m_wait  = 0;

  mem_req_if bus ();

`ifdef MEM_REQ_CTRL_STATS_EN
  logic [31:0] stat_accesses;
  logic [31:0] stat_wait_cycles;
`endif

  mem_req_ctrl #(.MAX_WAIT(MAXW), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    .stat_accesses    (stat_accesses),
    .stat_wait_cycles (stat_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          wait_cyc;
    logic [15:0] rdata;
    logic        merr;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_busy;
  } txn_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what the request should produce, from the request and memory behaviour alone.
  task automatic model(inout txn_t t);
    if (t.addr[0]) begin
      t.exp_rdata = 16'h0; t.exp_err = 1'b1; t.exp_to = 1'b0; t.exp_busy = 0;
    end else if (MAXW != 0 && t.wait_cyc >= MAXW) begin
      t.exp_rdata = 16'h0; t.exp_err = 1'b0; t.exp_to = 1'b1; t.exp_busy = MAXW;
    end else begin
      t.exp_rdata = t.wr ? 16'h0 : t.rdata; t.exp_err = t.merr; t.exp_to = 1'b0;
      t.exp_busy = t.wait_cyc + 1;
    end
  endtask

  task automatic stats_update(input txn_t t);
    if (t.exp_busy > 0) begin
      m_acc++;
      m_wait += t.exp_to ? t.exp_busy : t.exp_busy - 1;
    end
  endtask

  task automatic do_txn(input txn_t t, input string tag);
    int  busy_n;
    bit  got;
    busy_n = 0;
    got    = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_wr    = t.wr;
    bus.req_addr  = t.addr;
    bus.req_wdata = t.wdata;
    bus.mem_ready = 1'($urandom);
    bus.mem_err   = 1'($urandom);
    bus.mem_rdata = 16'($urandom);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
    bus.req_wr    = 1'($urandom);
    for (int k = 0; k < 20 && !got; k++) begin
      if (bus.resp_valid) begin
        got = 1'b1;
        chk({tag, ".latency"}, 32'(k), 32'(t.exp_busy));
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(t.exp_busy));
        chk({tag, ".rdata"}, 32'(bus.resp_rdata), 32'(t.exp_rdata));
        chk({tag, ".err"}, 32'(bus.resp_err), 32'(t.exp_err));
        chk({tag, ".timeout"}, 32'(bus.resp_timeout), 32'(t.exp_to));
        chk({tag, ".ready_in_done"}, 32'(bus.req_ready), 32'd1);
      end
      if (bus.mem_enable) begin
        busy_n++;
        chk({tag, ".mem_port"}, {15'd0, bus.mem_wr, bus.mem_addr}, {15'd0, t.wr, t.addr});
        chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(t.wdata));
        if (busy_n == t.wait_cyc + 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = t.rdata;
          bus.mem_err   = t.merr;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 16'($urandom);
          bus.mem_err   = 1'($urandom);
        end
      end else begin
        bus.mem_ready = 1'($urandom);
        bus.mem_err   = 1'($urandom);
        bus.mem_rdata = 16'($urandom);
      end
      if (!got) tick();
    end
    if (!got) chk({tag, ".resp_seen"}, 32'd0, 32'd1);
    stats_update(t);
    tick();
    chk({tag, ".one_cycle"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".hold"}, {14'd0, bus.resp_err, bus.resp_timeout, bus.resp_rdata},
        {14'd0, t.exp_err, t.exp_to, t.exp_rdata});
`ifdef MEM_REQ_CTRL_STATS_EN
    chk({tag, ".stat_acc"}, stat_accesses, 32'(m_acc));
    chk({tag, ".stat_wait"}, stat_wait_cycles, 32'(m_wait));
`endif
  endtask

  txn_t vec [8];
  txn_t rt;
  logic [15:0] b2b_addr [3];
  int          acc_cyc [3];

  initial begin
    // wr, addr, wdata, wait, mem_rdata, mem_err | exp rdata, err, timeout, busy cycles
    vec[0] = '{1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1};
    vec[1] = '{1'b1, 16'h0020, 16'h1234, 3, 16'h7777, 1'b0, 16'h0000, 1'b0, 1'b0, 4};
    vec[2] = '{1'b0, 16'h0031, 16'h0000, 0, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    vec[3] = '{1'b0, 16'h0040, 16'h0000, 9, 16'h3333, 1'b0, 16'h0000, 1'b0, 1'b1, 4};
    vec[4] = '{1'b0, 16'h0050, 16'h0000, 2, 16'hAAAA, 1'b1, 16'hAAAA, 1'b1, 1'b0, 3};
    vec[5] = '{1'b1, 16'h0060, 16'hC0DE, 3, 16'h1111, 1'b1, 16'h0000, 1'b1, 1'b0, 4};
    vec[6] = '{1'b1, 16'hFFFF, 16'h9999, 0, 16'h2222, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    vec[7] = '{1'b0, 16'h0000, 16'h0000, 0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1};

    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    bus.mem_ready = 1'b1; bus.mem_err = 1'b1; bus.mem_rdata = 16'hFFFF;
    tick();
    tick();
    chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset.resp", {13'd0, bus.resp_valid, bus.resp_err, bus.resp_timeout, bus.resp_rdata}, 32'd0);
    chk("reset.mem", {15'd0, bus.mem_enable, bus.mem_addr}, 32'd0);
    chk("reset.mem_wr_wdata", {15'd0, bus.mem_wr, bus.mem_wdata}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle.no_resp", 32'(bus.resp_valid), 32'd0);

    for (int i = 0; i < 8; i++) do_txn(vec[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rt.wr       = 1'($urandom);
      rt.addr     = 16'($urandom);
      if ($urandom_range(0, 5) != 0) rt.addr[0] = 1'b0;
      rt.wdata    = 16'($urandom);
      rt.wait_cyc = $urandom_range(0, 6);
      rt.rdata    = 16'($urandom);
      rt.merr     = ($urandom_range(0, 3) == 0);
      model(rt);
      do_txn(rt, $sformatf("rnd%0d", i));
    end

    // Async reset in the middle of a wait.
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 16'h0070; bus.mem_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rst.busy_before", 32'(bus.mem_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.enable_drop", {15'd0, bus.mem_enable, bus.mem_addr}, 32'd0);
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    m_acc = 0;
    m_wait = 0;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 5; k++) begin
        bus.mem_ready = 1'($urandom);
        tick();
        if (bus.resp_valid || bus.mem_enable) stray++;
      end
      chk("rst.no_resp", 32'(stray), 32'd0);
    end
    bus.mem_ready = 1'b0;
    do_txn(vec[4], "post_rst");

    // Request held valid with memory always ready: one accept every two cycles.
    b2b_addr[0] = 16'h0100; b2b_addr[1] = 16'h0202; b2b_addr[2] = 16'h0304;
    begin
      int idx, nresp;
      bit accepting;
      idx = 0;
      nresp = 0;
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = b2b_addr[0];
      for (int cyc = 0; cyc < 12; cyc++) begin
        bus.mem_ready = 1'b1;
        bus.mem_err   = 1'b0;
        bus.mem_rdata = bus.mem_addr ^ 16'h5A5A;
        if (bus.resp_valid) begin
          if (nresp < 3)
            chk($sformatf("b2b.rdata%0d", nresp), 32'(bus.resp_rdata), 32'(b2b_addr[nresp] ^ 16'h5A5A));
          nresp++;
        end
        accepting = bus.req_valid && bus.req_ready;
        if (accepting) acc_cyc[idx] = cyc;
        tick();
        if (accepting) begin
          idx++;
          if (idx == 3) bus.req_valid = 1'b0;
          else bus.req_addr = b2b_addr[idx];
        end
      end
      chk("b2b.accepts", 32'(idx), 32'd3);
      chk("b2b.responses", 32'(nresp), 32'd3);
      if (idx == 3) begin
        chk("b2b.gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        chk("b2b.gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
